flash_sample_streamer: RTL and testbench
========================================

# flash_sample_streamer

Parametrised successor to the music player datapath. It streams fixed-width audio samples out of packed words in flash over an Avalon-MM read master, one sample per `startsamplenow` strobe. Playback runs forward or backward, with pause, restart and address-range wrap. It sits between the flash controller and the audio codec sample register, with keyboard controls arriving already synchronised.

## Interface
Parameters:
- `ADDR_W`, 23: flash word-address width.
- `DATA_W`, 32: flash data width; must be an integer multiple of `SAMPLE_W`.
- `SAMPLE_W`, 16: sample width. Lane count is N = `DATA_W`/`SAMPLE_W`.
- `START_ADDR`, 0: first word of the playback range.
- `END_ADDR`, 23'h7FFFF: last word of the playback range, inclusive; must be ≥ `START_ADDR`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `kybrd_forward` in 1: 1 = forward playback, 0 = backward.
- `kybrd_pause` in 1: level; 1 = ignore sample strobes.
- `kybrd_restart` in 1: single-cycle pulse; jump to the start of the range.
- `startsamplenow` in 1: single-cycle sample-rate strobe.
- `flsh_address` out `ADDR_W`: read word address.
- `flsh_read` out 1: read request.
- `flsh_waitrequest` in 1: slave stall.
- `flsh_readdata` in `DATA_W`: read data.
- `flsh_readdatavalid` in 1: read data qualifier.
- `flsh_byteenable` out `DATA_W`/8: constant all-ones.
- `audio_data` out `SAMPLE_W`: current sample; held between updates.
- `sample_valid` out 1: pulses when `audio_data` updates.
- `underrun` out 1: pulses when a strobe finds no buffered data.

## Operation
- **Reset values:**
  - `flsh_read`=0, `audio_data`=0, `sample_valid`=0, `underrun`=0.
  - `flsh_address`=`START_ADDR`.
  - Word FIFO empty, no read outstanding.
- **Word FIFO:** two entries; the head word is the one currently being played.
  - Each entry stores the word and its direction bit, latched from `kybrd_forward` when its read was issued.
- **Fetch FSM:** states IDLE → REQ → WAIT → IDLE.
  - IDLE → REQ when FIFO occupancy < 2 and no read is outstanding.
  - REQ: `flsh_read`=1, address stable. Moves to WAIT on the first cycle with `flsh_waitrequest`=0.
  - WAIT: on `flsh_readdatavalid` the word is pushed, unless the discard flag is set.
  - At most one read outstanding.
- **Address step:** applied on read acceptance.
  - Forward: +1, with `END_ADDR` wrapping to `START_ADDR`.
  - Backward: −1, with `START_ADDR` wrapping to `END_ADDR`.
  - A direction change takes effect at the next issued read; buffered words keep their latched order.
- **Lane order:**
  - Forward words play lane 0 (bits `SAMPLE_W`-1:0) up to lane N−1.
  - Backward words play lane N−1 down to lane 0.
- **Strobe handling:** a strobe with pause=0 and FIFO non-empty outputs the head word's current lane and advances the lane. After the last lane, the head is popped.
  - Strobe with FIFO empty: `underrun` pulses, `audio_data` holds, nothing advances.
  - Pause=1: strobes are ignored entirely (no underrun). Prefetch continues until the FIFO is full.
- **Restart:**
  - Flushes the FIFO and resets the lane.
  - Sets the address to `START_ADDR` if forward, `END_ADDR` if backward.
  - If in REQ, drops `flsh_read` next cycle, unless accepted in the restart cycle, in which case it is treated as WAIT.
  - If in WAIT, sets the discard flag so the returning word is dropped; the flag clears on that `flsh_readdatavalid`.
  - `audio_data` holds.
- **Simultaneous events:**
  - Push and pop in the same cycle are both performed.
  - Restart has priority over a strobe and a push in the same cycle.
  - Reset overrides everything.

## Timing
- Strobe in cycle t with data available: `audio_data` and `sample_valid` update at t+1. `sample_valid` is high for exactly one cycle.
- `underrun` rises at t+1 for one cycle.
- First read is issued in the cycle after reset deasserts (`flsh_read`=1 at reset release +1).
- A word pushed in cycle t is playable by a strobe at t+1. Same-cycle bypass to the output is not allowed.

## Structure
- Package `audio_stream_pkg`:
  - fetch-state enum (IDLE/REQ/WAIT);
  - `lanes_f(DATA_W, SAMPLE_W)` function;
  - direction constants `DIR_FWD`/`DIR_BWD`.
- Sub-module `word_fifo2`: a 2-deep FIFO storing {dir, word}, with push, pop, flush, count and simultaneous push/pop.
- The top level contains the fetch FSM, address counter, lane counter and output registers.

## Test plan
- **Forward:** reset, waitrequest=0, data 32'hDEADBEEF returned after 20 cycles, two strobes → `audio_data`=16'hBEEF then 16'hDEAD; `flsh_address` goes 0, 1, 2.
- **Backward:** `kybrd_forward`=0, data 32'hAAAABBBB → first address 23'h7FFFF then 23'h7FFFE; samples 16'hAAAA then 16'hBBBB.
- **Underrun:** strobe before the first readdatavalid → `underrun`=1 for one cycle, `audio_data` stays 0, `sample_valid`=0.
- **Pause and stall:** pause=1 with 3 strobes → no output change, exactly 2 reads issued. Waitrequest held 5 cycles → `flsh_read` and address stable for all 6 cycles.
- **Wrap:** `START_ADDR`=4, `END_ADDR`=5, forward → addresses 4, 5, 4, 5.
- **Restart mid-read:** restart while in WAIT → the returning 32'h12345678 is dropped; the next read address is `START_ADDR`; the following strobe outputs the new word.

Source files
------------

// File: rtl/audio_stream_pkg.sv
// Shared types and helpers for the flash sample streamer: fetch states,
// lane arithmetic and playback direction encoding.
package audio_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  function automatic int lanes_f(input int data_w, input int sample_w);
    return data_w / sample_w;
  endfunction

  // Lane counter width; a single-lane word still gets a 1-bit counter.
  function automatic int lane_bits_f(input int lanes);
    int bits;
    bits = 1;
    while ((1 << bits) < lanes) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry FIFO of {dir, word}; head is the word currently being played.
// Flush wins over push and pop; push into a full FIFO is only taken alongside a pop.
module word_fifo2 #(
  parameter int WORD_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/flash_sample_streamer.sv
// Streams SAMPLE_W-wide samples out of packed flash words, one per strobe,
// forward or backward over [START_ADDR, END_ADDR] with pause and restart.
module flash_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter int                DATA_W     = 32,
  parameter int                SAMPLE_W   = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kybrd_forward,
  input  logic                  kybrd_pause,
  input  logic                  kybrd_restart,
  input  logic                  startsamplenow,
  output logic [ADDR_W-1:0]     flsh_address,
  output logic                  flsh_read,
  input  logic                  flsh_waitrequest,
  input  logic [DATA_W-1:0]     flsh_readdata,
  input  logic                  flsh_readdatavalid,
  output logic [DATA_W/8-1:0]   flsh_byteenable,
  output logic [SAMPLE_W-1:0]   audio_data,
  output logic                  sample_valid,
  output logic                  underrun
);

  localparam int                LANES     = lanes_f(DATA_W, SAMPLE_W);
  localparam int                LANE_W    = lane_bits_f(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic fwd);
    if (fwd == DIR_FWD) return (a == END_ADDR) ? START_ADDR : a + 1'b1;
    else                return (a == START_ADDR) ? END_ADDR : a - 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] base_addr(input logic fwd);
    return (fwd == DIR_BWD) ? END_ADDR : START_ADDR;
  endfunction

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  pend_dir_q, pend_dir_d;
  logic                  discard_q, discard_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [SAMPLE_W-1:0]   audio_q, audio_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;

  logic                  accept;
  logic                  fifo_push, fifo_pop;
  logic [DATA_W:0]       fifo_head;
  logic [1:0]            fifo_count;
  logic                  head_dir;
  logic [DATA_W-1:0]     head_word;
  logic [LANE_W-1:0]     lane_sel;
  logic [SAMPLE_W-1:0]   head_sample;

  word_fifo2 #(.WORD_W(DATA_W + 1)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i ({pend_dir_q, flsh_readdata}),
    .pop_i       (fifo_pop),
    .flush_i     (kybrd_restart),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign accept = (state_q == REQ) && !flsh_waitrequest;

  // Fetch FSM and address counter
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_dir_d = pend_dir_q;
    discard_d  = discard_q;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_count < 2'd2) || kybrd_restart) state_d = REQ;
      end
      REQ: begin
        if (accept) begin
          state_d    = WAIT;
          pend_dir_d = kybrd_forward;
          // Accepted in the restart cycle: the word belongs to the old stream.
          if (kybrd_restart) discard_d = 1'b1;
        end else if (kybrd_restart) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flsh_readdatavalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          fifo_push = !discard_q && !kybrd_restart;
        end else if (kybrd_restart) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kybrd_restart)  addr_d = base_addr(kybrd_forward);
    else if (accept)    addr_d = step_addr(addr_q, kybrd_forward);
  end

  assign head_dir  = fifo_head[DATA_W];
  assign head_word = fifo_head[DATA_W-1:0];
  assign lane_sel  = (head_dir == DIR_FWD) ? lane_q : LAST_LANE - lane_q;

  always_comb begin
    head_sample = '0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(lane_sel) == i) head_sample = head_word[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Strobe handling: lane counter, pop and output registers
  always_comb begin
    lane_d     = lane_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    if (kybrd_restart) begin
      lane_d = '0;
    end else if (startsamplenow && !kybrd_pause) begin
      if (fifo_count == 2'd0) begin
        underrun_d = 1'b1;
      end else begin
        audio_d = head_sample;
        valid_d = 1'b1;
        if (lane_q == LAST_LANE) begin
          lane_d   = '0;
          fifo_pop = 1'b1;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= START_ADDR;
      pend_dir_q <= DIR_FWD;
      discard_q  <= 1'b0;
      lane_q     <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_dir_q <= pend_dir_d;
      discard_q  <= discard_d;
      lane_q     <= lane_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign flsh_address    = addr_q;
  assign flsh_read       = (state_q == REQ);
  assign flsh_byteenable = '1;
  assign audio_data      = audio_q;
  assign sample_valid    = valid_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Scoreboard bench for flash_sample_streamer: a flash slave model answers reads,
// expected samples are queued per strobe and compared when sample_valid fires.
module tb_flash_sample_streamer;

  logic        clk;
  logic        reset;
  logic        kybrd_forward, kybrd_pause, kybrd_restart, startsamplenow;
  logic [22:0] flsh_address;
  logic        flsh_read;
  logic        flsh_waitrequest;
  logic [31:0] flsh_readdata;
  logic        flsh_readdatavalid;
  logic [3:0]  flsh_byteenable;
  logic [15:0] audio_data;
  logic        sample_valid, underrun;

  logic        w_strobe;
  logic [22:0] w_address;
  logic        w_read;
  logic [31:0] w_rdata;
  logic        w_rdv;
  logic [3:0]  w_be;
  logic [15:0] w_audio;
  logic        w_valid, w_underrun;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [22:0] acc_addr[$];
  int          acc_cycles[$];
  logic [22:0] w_addrs[$];
  int          sv_cnt = 0;

  int          stall_left = 0;
  int          rsp_lat = 1;
  int          cd = 0;
  int          req_cycles = 0;
  logic [22:0] req_addr = '0;
  bit          addr_moved = 0;
  logic [31:0] pend_data = '0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = '0;
  bit          w_pend = 0;
  logic [22:0] w_addr_p = '0;

  flash_sample_streamer dut (
    .clk                (clk),
    .reset              (reset),
    .kybrd_forward      (kybrd_forward),
    .kybrd_pause        (kybrd_pause),
    .kybrd_restart      (kybrd_restart),
    .startsamplenow     (startsamplenow),
    .flsh_address       (flsh_address),
    .flsh_read          (flsh_read),
    .flsh_waitrequest   (flsh_waitrequest),
    .flsh_readdata      (flsh_readdata),
    .flsh_readdatavalid (flsh_readdatavalid),
    .flsh_byteenable    (flsh_byteenable),
    .audio_data         (audio_data),
    .sample_valid       (sample_valid),
    .underrun           (underrun)
  );

  flash_sample_streamer #(.START_ADDR(23'd4), .END_ADDR(23'd5)) u_wrap (
    .clk                (clk),
    .reset              (reset),
    .kybrd_forward      (1'b1),
    .kybrd_pause        (1'b0),
    .kybrd_restart      (1'b0),
    .startsamplenow     (w_strobe),
    .flsh_address       (w_address),
    .flsh_read          (w_read),
    .flsh_waitrequest   (1'b0),
    .flsh_readdata      (w_rdata),
    .flsh_readdatavalid (w_rdv),
    .flsh_byteenable    (w_be),
    .audio_data         (w_audio),
    .sample_valid       (w_valid),
    .underrun           (w_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [22:0] a);
    if (a == 23'd0)       return 32'hDEADBEEF;
    if (a == 23'h7FFFF)   return 32'hAAAABBBB;
    return {a[15:0] ^ 16'h1111, a[15:0]};
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_addr.size()) return 32'(acc_addr[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] w_at(input int i);
    if (i < w_addrs.size()) return 32'(w_addrs[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Flash slave for the main DUT, driven away from the active edge.
  always @(negedge clk) begin
    flsh_readdatavalid = 1'b0;
    if (reset) begin
      cd = 0;
      req_cycles = 0;
      flsh_waitrequest = 1'b0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          flsh_readdatavalid = 1'b1;
          flsh_readdata = pend_data;
        end
      end
      if (flsh_read) begin
        if (req_cycles == 0) req_addr = flsh_address;
        else if (flsh_address != req_addr) addr_moved = 1;
        req_cycles++;
        if (stall_left > 0) begin
          flsh_waitrequest = 1'b1;
          stall_left--;
        end else begin
          flsh_waitrequest = 1'b0;
          acc_addr.push_back(flsh_address);
          acc_cycles.push_back(req_cycles);
          req_cycles = 0;
          cd = rsp_lat;
          pend_data = ovr_en ? ovr_data : word_of(flsh_address);
          ovr_en = 0;
        end
      end else begin
        flsh_waitrequest = 1'b0;
        req_cycles = 0;
      end
    end
  end

  // Zero-wait slave for the wrap instance: data one cycle after acceptance.
  always @(negedge clk) begin
    w_rdv = 1'b0;
    if (reset) begin
      w_pend = 0;
    end else begin
      if (w_pend) begin
        w_rdv = 1'b1;
        w_rdata = {16'(w_addr_p) + 16'h0100, 16'(w_addr_p)};
        w_pend = 0;
      end
      if (w_read) begin
        w_pend = 1;
        w_addr_p = w_address;
        w_addrs.push_back(w_address);
      end
    end
  end

  // Scoreboard output side
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      sv_cnt++;
      if (exp_q.size() > 0) chk("sample", 32'(audio_data), 32'(exp_q.pop_front()));
      else                  chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
    end
  end

  task automatic do_reset(input logic fwd, input logic pause, input logic rst_restart,
                          input int stall, input int lat);
    @(negedge clk);
    reset = 1'b1;
    kybrd_forward = fwd;
    kybrd_pause = pause;
    kybrd_restart = 1'b0;
    startsamplenow = 1'b0;
    w_strobe = 1'b0;
    repeat (2) @(negedge clk);
    acc_addr.delete();
    acc_cycles.delete();
    w_addrs.delete();
    exp_q.delete();
    addr_moved = 0;
    stall_left = stall;
    rsp_lat = lat;
    reset = 1'b0;
    kybrd_restart = rst_restart;
    @(negedge clk);
    kybrd_restart = 1'b0;
  endtask

  // Called at a negedge; strobes for one cycle and checks the following two cycles.
  task automatic strobe(input string tag, input bit exp_out, input logic [15:0] exp_val,
                        input bit exp_under);
    logic [15:0] prev;
    prev = audio_data;
    startsamplenow = 1'b1;
    if (exp_out) exp_q.push_back(exp_val);
    @(negedge clk);
    startsamplenow = 1'b0;
    chk({tag, "_valid"}, 32'(sample_valid), 32'(exp_out));
    chk({tag, "_underrun"}, 32'(underrun), 32'(exp_under));
    if (!exp_out) chk({tag, "_hold"}, 32'(audio_data), 32'(prev));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(sample_valid), 32'd0);
    chk({tag, "_underrun_drop"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int sv0;
    reset = 1'b1;
    kybrd_forward = 1'b1;
    kybrd_pause = 1'b0;
    kybrd_restart = 1'b0;
    startsamplenow = 1'b0;
    w_strobe = 1'b0;
    flsh_waitrequest = 1'b0;
    flsh_readdata = '0;
    flsh_readdatavalid = 1'b0;
    w_rdata = '0;
    w_rdv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(flsh_read), 32'd0);
    chk("rst_addr", 32'(flsh_address), 32'd0);
    chk("rst_audio", 32'(audio_data), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("byteenable", 32'(flsh_byteenable), 32'hF);

    // Forward playback with an early strobe hitting an empty FIFO
    do_reset(1'b1, 1'b0, 1'b0, 0, 20);
    chk("fwd_first_read", 32'(flsh_read), 32'd1);
    chk("fwd_first_addr", 32'(flsh_address), 32'd0);
    strobe("underrun", 1'b0, 16'h0, 1'b1);
    chk("underrun_audio", 32'(audio_data), 32'd0);
    repeat (60) @(negedge clk);
    chk("fwd_acc0", acc_at(0), 32'd0);
    chk("fwd_acc1", acc_at(1), 32'd1);
    chk("fwd_addr_now", 32'(flsh_address), 32'd2);
    strobe("fwd_s0", 1'b1, 16'hBEEF, 1'b0);
    strobe("fwd_s1", 1'b1, 16'hDEAD, 1'b0);

    // Pause with a stalled first read
    do_reset(1'b1, 1'b1, 1'b0, 5, 3);
    chk("stall_read", 32'(flsh_read), 32'd1);
    repeat (30) @(negedge clk);
    chk("stall_cycles", 32'(acc_cycles.size() > 0 ? acc_cycles[0] : -1), 32'd6);
    chk("stall_addr_stable", 32'(addr_moved), 32'd0);
    sv0 = sv_cnt;
    for (int i = 0; i < 3; i++) strobe("pause", 1'b0, 16'h0, 1'b0);
    repeat (10) @(negedge clk);
    chk("pause_reads", 32'(acc_addr.size()), 32'd2);
    chk("pause_no_out", 32'(sv_cnt - sv0), 32'd0);
    kybrd_pause = 1'b0;
    strobe("unpause_s0", 1'b1, 16'hBEEF, 1'b0);
    strobe("unpause_s1", 1'b1, 16'hDEAD, 1'b0);

    // Backward playback, restart issued in the reset-release cycle
    do_reset(1'b0, 1'b0, 1'b1, 0, 2);
    chk("bwd_first_read", 32'(flsh_read), 32'd1);
    chk("bwd_first_addr", 32'(flsh_address), 32'h7FFFF);
    repeat (20) @(negedge clk);
    chk("bwd_acc0", acc_at(0), 32'h7FFFF);
    chk("bwd_acc1", acc_at(1), 32'h7FFFE);
    strobe("bwd_s0", 1'b1, 16'hAAAA, 1'b0);
    strobe("bwd_s1", 1'b1, 16'hBBBB, 1'b0);

    // Restart while a read is outstanding: its data must be dropped
    ovr_en = 1;
    ovr_data = 32'h12345678;
    do_reset(1'b1, 1'b0, 1'b0, 0, 10);
    repeat (3) @(negedge clk);
    kybrd_restart = 1'b1;
    @(negedge clk);
    kybrd_restart = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_acc0", acc_at(0), 32'd0);
    chk("rst_mid_acc1", acc_at(1), 32'd0);
    strobe("rst_mid_s0", 1'b1, 16'hBEEF, 1'b0);

    // Address wrap on the small-range instance
    do_reset(1'b1, 1'b0, 1'b0, 0, 1);
    repeat (6) @(negedge clk);
    w_strobe = 1'b1;
    @(negedge clk);
    w_strobe = 1'b0;
    chk("wrap_s0", 32'(w_audio), 32'd4);
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      w_strobe = 1'b1;
      @(negedge clk);
      w_strobe = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("wrap_a0", w_at(0), 32'd4);
    chk("wrap_a1", w_at(1), 32'd5);
    chk("wrap_a2", w_at(2), 32'd4);
    chk("wrap_a3", w_at(3), 32'd5);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
